// File: rtl/handshake_ctrl.sv
// rtl/handshake_ctrl.sv - picoMips input-handshake sequencer with sync, debounce and operand snapshot
module handshake_ctrl #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CNT_W           = 5
) (
  input  logic       Clock,
  input  logic       nReset,
  input  logic       HandshakeIn,
  input  logic [7:0] SwIn,
  input  logic       WaitReq,
  output logic       Go,
  output logic [7:0] SwData,
  output logic       Pending,
  output logic [7:0] PressCount
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PRESS_DB = 3'd1,
    ST_ARMED    = 3'd2,
    ST_GO       = 3'd3,
    ST_REL_WAIT = 3'd4,
    ST_REL_DB   = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0]      hs_sync_q, hs_sync_d;
  logic [SYNC_STAGES-1:0][7:0] sw_sync_q, sw_sync_d;
  logic                        hs_s;
  logic [7:0]                  sw_s;

  state_t          state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [7:0]      sw_data_q, sw_data_d;
  logic [7:0]      press_count_q, press_count_d;

  // Synchroniser shift: the raw inputs enter at bit 0, the settled copy leaves at the top bit.
  always_comb begin
    hs_sync_d = {hs_sync_q[SYNC_STAGES-2:0], HandshakeIn};
    sw_sync_d = {sw_sync_q[SYNC_STAGES-2:0], SwIn};
  end

  assign hs_s = hs_sync_q[SYNC_STAGES-1];
  assign sw_s = sw_sync_q[SYNC_STAGES-1];

  // Synchroniser flops; cleared on reset so a stale switch level is never seen as a press.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      hs_sync_q <= '0;
      sw_sync_q <= '0;
    end else begin
      hs_sync_q <= hs_sync_d;
      sw_sync_q <= sw_sync_d;
    end
  end

  // Press/release sequencing: debounce both edges, hold the press until the core waits, pulse Go once.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    sw_data_d     = sw_data_q;
    press_count_d = press_count_q;
    case (state_q)
      ST_IDLE: begin
        if (hs_s) begin
          state_d = ST_PRESS_DB;
          cnt_d   = '0;
        end
      end
      ST_PRESS_DB: begin
        if (!hs_s) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_ARMED;
          sw_data_d = sw_s;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_ARMED: begin
        // An early release is deliberately ignored here and picked up in REL_WAIT.
        if (WaitReq) begin
          state_d = ST_GO;
        end
      end
      ST_GO: begin
        press_count_d = press_count_q + 8'd1;
        state_d       = ST_REL_WAIT;
      end
      ST_REL_WAIT: begin
        if (!hs_s) begin
          state_d = ST_REL_DB;
          cnt_d   = '0;
        end
      end
      ST_REL_DB: begin
        if (hs_s) begin
          state_d = ST_REL_WAIT;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Sequencer state, debounce counter, operand snapshot and Go counter.
  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state_q       <= ST_IDLE;
      cnt_q         <= '0;
      sw_data_q     <= 8'h00;
      press_count_q <= 8'h00;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      sw_data_q     <= sw_data_d;
      press_count_q <= press_count_d;
    end
  end

  // Moore outputs decoded straight from the state register so reset clears them immediately.
  always_comb begin
    Go         = (state_q == ST_GO);
    Pending    = (state_q == ST_ARMED);
    SwData     = sw_data_q;
    PressCount = press_count_q;
  end

endmodule
